// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types and constants for the instruction-fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, word width, ISA NOP, enable levels, PC helpers.
package fetch_ctrl_pkg;

  localparam int WORD_DATA_W = 32;

  // RISC-V canonical NOP (addi x0, x0, 0); what IF/ID sees for squashed fetches.
  localparam logic [WORD_DATA_W-1:0] ISA_NOP = 32'h0000_0013;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Sequential fetch stride in bytes.
  localparam logic [WORD_DATA_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    FC_IDLE  = 2'd0,  // one cycle after reset before the first request
    FC_FETCH = 2'd1,  // request outstanding, response will be used
    FC_HOLD  = 2'd2,  // instruction captured, waiting for ID to accept it
    FC_DROP  = 2'd3   // request outstanding, response is stale and discarded
  } fc_state_t;

  // Force an address onto a 32-bit word boundary.
  function automatic logic [WORD_DATA_W-1:0] word_align(input logic [WORD_DATA_W-1:0] addr);
    return addr & ~32'h3;
  endfunction

  // Next sequential PC; wraps modulo 2^32.
  function automatic logic [WORD_DATA_W-1:0] pc_next(input logic [WORD_DATA_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// fetch_wait_timer: saturating bus wait counter with a sticky timeout flag.
// Latency: err rises on the clock edge that takes the wait count to MAX_WAIT.
// Backpressure: none; it only observes the request/ready pair.
// Ports: clk, reset (async, active-high); busy = request raised, done = ready seen,
//        clr_err = clears the sticky flag; err = sticky timeout flag.
module fetch_wait_timer #(
  parameter int MAX_WAIT = 16  // legal range 2..255
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  input  logic done,
  input  logic clr_err,
  output logic err
);

  localparam logic [7:0] CNT_MAX = 8'hFF;
  // The flag sets on the increment that lands exactly on MAX_WAIT, so the
  // trigger is the count value just before it.
  localparam logic [7:0] ERR_AT  = 8'(MAX_WAIT - 1);

  logic [7:0] wait_cnt;
  logic       waiting;

  assign waiting = busy & ~done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (done) begin
        wait_cnt <= '0;
      end else if (busy && (wait_cnt != CNT_MAX)) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      // Clear wins over set: once the count has passed MAX_WAIT it never
      // re-triggers, so a clear during a stuck request really sticks.
      if (clr_err) begin
        err <= 1'b0;
      end else if (waiting && (wait_cnt == ERR_AT)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer between the imem bus and the IF/ID register.
// Latency: zero-wait memory gives one insn per cycle; insn/fetch_pc update on the edge that sees mem_rdy.
// Backpressure: id_stall parks in HOLD with mem_req low; a raised mem_req/mem_addr is held until mem_rdy.
// Optional feature: define FETCH_PERF_CNT_EN to build perf_fetch/perf_stall counters; otherwise both read 0.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   id_stall              ID/hazard stall request
//   flush/new_pc          pipeline flush and its target (highest priority redirect)
//   br_taken/br_addr      taken branch and its target
//   mem_req/mem_addr      fetch request and word-aligned address
//   mem_rdy/mem_rdata     response valid / request accepted, and fetched word
//   fetch_pc/insn         PC and instruction presented to IF/ID
//   if_stall              IF/ID capture inhibit
//   fetch_err             sticky wait-timeout flag
//   perf_fetch/perf_stall retired-fetch and stall-cycle counters
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_stall,
  input  logic                   flush,
  input  logic [WORD_DATA_W-1:0] new_pc,
  input  logic                   br_taken,
  input  logic [WORD_DATA_W-1:0] br_addr,
  output logic                   mem_req,
  output logic [WORD_DATA_W-1:0] mem_addr,
  input  logic                   mem_rdy,
  input  logic [WORD_DATA_W-1:0] mem_rdata,
  output logic [WORD_DATA_W-1:0] fetch_pc,
  output logic [WORD_DATA_W-1:0] insn,
  output logic                   if_stall,
  output logic                   fetch_err,
  output logic [31:0]            perf_fetch,
  output logic [31:0]            perf_stall
);

  localparam logic [WORD_DATA_W-1:0] PC_INIT = word_align(RESET_PC);

  fc_state_t              state;
  logic [WORD_DATA_W-1:0] pc;        // address of the current / next request
  logic [WORD_DATA_W-1:0] redir_pc;  // target parked while a stale response drains

  logic                   redirect;
  logic [WORD_DATA_W-1:0] redir_tgt;

  // flush outranks a taken branch in the same cycle.
  assign redirect  = flush | br_taken;
  assign redir_tgt = word_align(flush ? new_pc : br_addr);

  // pc is only ever changed on a handshake or while mem_req is low, so
  // driving the address straight from it keeps it stable for the bus.
  // In DROP, pc still holds the old address of the stale request.
  assign mem_addr = pc;

  // IF/ID may capture only in FETCH on the cycle the data arrives and ID is free.
  assign if_stall = id_stall | (state != FC_FETCH) | ~mem_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FC_IDLE;
      pc       <= PC_INIT;
      redir_pc <= PC_INIT;
      mem_req  <= DISABLE;
      insn     <= ISA_NOP;
      fetch_pc <= PC_INIT;
    end else begin
      case (state)
        FC_IDLE: begin
          state   <= FC_FETCH;
          mem_req <= ENABLE;
        end

        FC_FETCH: begin
          if (mem_rdy) begin
            if (redirect) begin
              // Response belongs to the wrong path: squash it and restart at the target.
              insn <= ISA_NOP;
              pc   <= redir_tgt;
            end else begin
              insn     <= mem_rdata;
              fetch_pc <= pc;
              if (id_stall) begin
                state   <= FC_HOLD;
                mem_req <= DISABLE;
              end else begin
                pc <= pc_next(pc);
              end
            end
          end else if (redirect) begin
            // Request cannot be withdrawn; remember where to go once it completes.
            redir_pc <= redir_tgt;
            insn     <= ISA_NOP;
            state    <= FC_DROP;
          end
        end

        FC_HOLD: begin
          if (redirect) begin
            pc      <= redir_tgt;
            state   <= FC_FETCH;
            mem_req <= ENABLE;
          end else if (!id_stall) begin
            pc      <= pc_next(pc);
            state   <= FC_FETCH;
            mem_req <= ENABLE;
          end
        end

        FC_DROP: begin
          if (mem_rdy) begin
            // A redirect arriving on the completing cycle is the newest target.
            insn  <= ISA_NOP;
            pc    <= redirect ? redir_tgt : redir_pc;
            state <= FC_FETCH;
          end else if (redirect) begin
            redir_pc <= redir_tgt;
          end
        end

        default: begin
          state   <= FC_IDLE;
          mem_req <= DISABLE;
        end
      endcase
    end
  end

  fetch_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .busy    (mem_req),
    .done    (mem_rdy),
    .clr_err (flush),
    .err     (fetch_err)
  );

`ifdef FETCH_PERF_CNT_EN
  logic        fetch_retire;
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_stall_q;

  // Accepted and used: a handshake in FETCH that no redirect squashes.
  assign fetch_retire = (state == FC_FETCH) & mem_rdy & ~redirect;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (fetch_retire) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (if_stall) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_stall = perf_stall_q;
`else
  assign perf_fetch = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl with a transaction-level reference model.
// Latency: model updates on posedge, monitor compares on negedge.
// Backpressure: bench memory answers only while mem_req is high, with random or directed delay.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          MAXW   = 16;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = '0;
  logic        br_taken = 1'b0;
  logic [31:0] br_addr = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rdy = 1'b0;
  logic [31:0] mem_rdata;
  logic [31:0] fetch_pc;
  logic [31:0] insn;
  logic        if_stall;
  logic        fetch_err;
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;

  fetch_ctrl #(.RESET_PC(RST_PC), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset), .id_stall(id_stall), .flush(flush), .new_pc(new_pc),
    .br_taken(br_taken), .br_addr(br_addr), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .fetch_pc(fetch_pc), .insn(insn),
    .if_stall(if_stall), .fetch_err(fetch_err), .perf_fetch(perf_fetch), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign mem_rdata = mem_rdy ? mem_word(mem_addr) : 32'hDEAD_BEEF;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (bus-transaction view) ----------------
  typedef struct {
    logic [31:0] insn;
    logic [31:0] pc;
  } cpl_t;

  logic [31:0] req_q[$];  // addresses of requests the DUT must start, in order
  cpl_t        cpl_q[$];  // IF/ID contents expected after each bus completion

  bit          m_idle, m_parked, m_busy, m_stale;
  logic [31:0] m_pc, m_tgt, m_insn, m_fpc;
  int          m_wait;
  bit          m_err;
  logic [31:0] m_pf, m_ps;

  task automatic model_reset();
    m_idle = 1; m_parked = 0; m_busy = 0; m_stale = 0;
    m_pc = RST_PC; m_tgt = RST_PC; m_insn = NOP; m_fpc = RST_PC;
    m_wait = 0; m_err = 0; m_pf = '0; m_ps = '0;
    req_q.delete();
    cpl_q.delete();
  endtask

  task automatic model_step();
    bit          redir;
    logic [31:0] tgt;
    redir = flush | br_taken;
    tgt   = (flush ? new_pc : br_addr) & ~32'h3;

    // IF/ID may take data only when a live request completes and ID is free.
    if (id_stall || !(m_busy && !m_stale) || !mem_rdy) m_ps = m_ps + 32'd1;

    // Wait timer: count stalled request cycles; error on reaching MAXW.
    if (flush) m_err = 0;
    else if (m_busy && !mem_rdy && (m_wait + 1 == MAXW)) m_err = 1;
    if (mem_rdy) m_wait = 0;
    else if (m_busy && m_wait < 255) m_wait++;

    if (m_idle) begin
      m_idle = 0; m_busy = 1;
      req_q.push_back(m_pc);
    end else if (m_parked) begin
      if (redir || !id_stall) begin
        m_pc = redir ? tgt : m_pc + 32'd4;
        m_parked = 0; m_busy = 1;
        req_q.push_back(m_pc);
      end
    end else if (m_busy) begin
      if (mem_rdy) begin
        if (m_stale || redir) begin
          m_insn = NOP;
          m_pc = redir ? tgt : m_tgt;
          m_stale = 0;
          req_q.push_back(m_pc);
        end else begin
          m_insn = mem_word(m_pc);
          m_fpc  = m_pc;
          m_pf   = m_pf + 32'd1;
          if (id_stall) begin
            m_parked = 1; m_busy = 0;
          end else begin
            m_pc = m_pc + 32'd4;
            req_q.push_back(m_pc);
          end
        end
        cpl_q.push_back('{m_insn, m_fpc});
      end else if (redir) begin
        m_stale = 1; m_tgt = tgt; m_insn = NOP;
      end
    end
  endtask

  always @(posedge clk) begin
    if (!reset) model_step();
  end

  // ---------------- monitor ----------------
  bit          new_req = 1'b1;
  logic [31:0] held_addr = '0;
  bit          exp_stall;
  cpl_t        c;

  always @(negedge clk) begin
    if (reset) begin
      new_req = 1'b1;
    end else begin
      exp_stall = id_stall | !(m_busy && !m_stale) | !mem_rdy;
      chk_bit("if_stall", if_stall, exp_stall);
      chk_bit("mem_req", mem_req, m_busy);
      chk_bit("fetch_err", fetch_err, m_err);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetch", perf_fetch, m_pf);
      chk("perf_stall", perf_stall, m_ps);
`else
      chk("perf_fetch_off", perf_fetch, 32'd0);
      chk("perf_stall_off", perf_stall, 32'd0);
`endif
      if (mem_req) begin
        if (new_req) begin
          if (req_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL req_unexpected: got request at %h, none expected (t=%0t)", mem_addr, $time);
          end else begin
            chk("req_addr", mem_addr, req_q.pop_front());
          end
          held_addr = mem_addr;
        end else begin
          chk("req_stable", mem_addr, held_addr);
        end
      end
      new_req = !mem_req || mem_rdy;

      if (cpl_q.size() != 0) begin
        c = cpl_q.pop_front();
        chk("cpl_insn", insn, c.insn);
        chk("cpl_fetch_pc", fetch_pc, c.pc);
      end else begin
        chk("held_insn", insn, m_insn);
        chk("held_fetch_pc", fetch_pc, m_fpc);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit rdy, input bit stall, input bit br, input bit fl,
                       input logic [31:0] ba, input logic [31:0] np);
    @(posedge clk); #1;
    mem_rdy  = rdy & mem_req;
    id_stall = stall;
    br_taken = br;
    flush    = fl;
    br_addr  = ba;
    new_pc   = np;
  endtask

  task automatic run(input int cycles, input int p_rdy, input int p_stall, input int p_redir);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      mem_rdy  = mem_req && ($urandom_range(0, 99) < p_rdy);
      id_stall = ($urandom_range(0, 99) < p_stall);
      br_taken = ($urandom_range(0, 99) < p_redir);
      flush    = ($urandom_range(0, 99) < p_redir / 2);
      br_addr  = $urandom;
      new_pc   = $urandom;
    end
  endtask

  task automatic check_reset_values();
    chk_bit("rst_mem_req", mem_req, 1'b0);
    chk_bit("rst_if_stall", if_stall, 1'b1);
    chk("rst_insn", insn, NOP);
    chk_bit("rst_fetch_err", fetch_err, 1'b0);
    chk("rst_mem_addr", mem_addr, RST_PC);
    chk("rst_perf_fetch", perf_fetch, 32'd0);
    chk("rst_perf_stall", perf_stall, 32'd0);
  endtask

  // Assert reset between clock edges so only the asynchronous path can clear state.
  task automatic do_reset();
    @(posedge clk); #3;
    reset = 1'b1;
    mem_rdy = 1'b0; id_stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    #2 reset = 1'b0;

    // Zero-wait streaming from reset.
    repeat (6) drive(1, 0, 0, 0, 0, 0);
    // Redirect to 0x10, then three wait cycles before the response.
    drive(1, 0, 0, 1, 0, 32'h10);
    repeat (3) drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    // Branch during a wait at 0x20, response two cycles later is dropped.
    drive(1, 0, 0, 1, 0, 32'h20);
    drive(0, 0, 1, 0, 32'h100, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    // flush and branch together: flush target wins.
    drive(1, 0, 1, 1, 32'h300, 32'h200);
    repeat (2) drive(1, 0, 0, 0, 0, 0);
    // ID stall after fetching 0x40, released after five cycles.
    drive(1, 0, 0, 1, 0, 32'h40);
    drive(1, 1, 0, 0, 0, 0);
    repeat (5) drive(1, 1, 0, 0, 0, 0);
    repeat (3) drive(1, 0, 0, 0, 0, 0);
    // Long wait: timeout flag sets, survives the response, cleared by flush.
    repeat (20) drive(0, 0, 0, 0, 0, 0);
    repeat (3) drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 32'h80);
    repeat (2) drive(1, 0, 0, 0, 0, 0);
    // PC wrap at the top of the address space (unaligned target gets masked).
    drive(1, 0, 0, 1, 0, 32'hFFFF_FFF9);
    repeat (4) drive(1, 0, 0, 0, 0, 0);

    // Randomized traffic.
    run(1500, 60, 20, 8);
    run(1000, 25, 40, 15);
    run(300, 3, 5, 4);
    run(500, 100, 0, 0);

    // Reset in the middle of an outstanding request, then a short counted run.
    run(7, 30, 10, 10);
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    repeat (6) drive(1, 0, 0, 0, 0, 0);
    repeat (3) drive(1, 1, 0, 0, 0, 0);
    repeat (6) drive(1, 0, 0, 0, 0, 0);

    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("req_q_drain", 32'(req_q.size()), 32'd0);
    chk("cpl_q_drain", 32'(cpl_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer sitting between the instruction memory bus and the IF/ID pipeline register.
- Owns the fetch PC and issues one outstanding request at a time with a req/rdy handshake.
- Drives the IF-stage stall so the IF/ID register captures only valid instructions.
- Absorbs redirects (flush, taken branch) that arrive while a request is in flight, discarding the stale response.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- MAX_WAIT, 16, wait-cycle count at which fetch_err is raised (range 2..255).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- id_stall  in  1  downstream stall request from ID/hazard logic
- flush  in  1  pipeline flush; redirect to new_pc
- new_pc  in  32  flush target
- br_taken  in  1  branch taken; redirect to br_addr
- br_addr  in  32  branch target
- mem_req  out  1  fetch request
- mem_addr  out  32  fetch address, word aligned
- mem_rdy  in  1  response valid / request accepted
- mem_rdata  in  32  fetched instruction
- fetch_pc  out  32  PC of insn
- insn  out  32  fetched instruction to IF/ID register
- if_stall  out  1  stall to IF/ID register
- fetch_err  out  1  sticky wait-timeout flag
- perf_fetch  out  32  retired-fetch count (optional feature)
- perf_stall  out  32  if_stall cycle count (optional feature)

Behaviour:
- Reset values, applied asynchronously: state=IDLE, pc=RESET_PC, mem_req=0, insn=ISA_NOP, if_stall=1, fetch_err=0, wait_cnt=0, perf counters=0.
- Redirect priority: flush over br_taken. Target is new_pc or br_addr; bits [1:0] are forced to 0.
- The bus rule is fixed: once mem_req=1, mem_req and mem_addr stay stable until mem_rdy. A request is never withdrawn.
- IDLE: go to FETCH on the first cycle after reset deasserts.
- FETCH: mem_req=1, mem_addr=pc.
  - mem_rdy and no redirect: insn<=mem_rdata, fetch_pc<=pc. If id_stall=0, pc<=pc+4 and stay in FETCH (zero-wait gives 1 insn/cycle). If id_stall=1, go to HOLD.
  - mem_rdy with redirect: drop the data (insn<=ISA_NOP), pc<=target, stay in FETCH.
  - mem_rdy=0 with redirect: latch the target into redir_pc and go to DROP.
- HOLD: mem_req=0, insn held.
  - id_stall falling: pc<=pc+4, go to FETCH.
  - Redirect: pc<=target, go to FETCH.
- DROP: mem_req=1 at the old address. On mem_rdy, discard the data, pc<=redir_pc, go to FETCH. A newer redirect while in DROP overwrites redir_pc.
- if_stall = id_stall | (state!=FETCH) | (state==FETCH & !mem_rdy). Result: if_stall=1 in IDLE, DROP and HOLD, and in FETCH until mem_rdy.
- wait_cnt:
  - Increments each cycle mem_req=1 & !mem_rdy, saturating at 255.
  - Clears on mem_rdy.
  - Reaching MAX_WAIT sets fetch_err. fetch_err is sticky and is cleared only by flush or reset.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0.
- Reset asserted mid-request immediately forces IDLE. The outstanding bus response is not tracked; the memory side is reset by the same signal.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: perf_fetch increments on each accepted, non-dropped fetch. perf_stall increments on each cycle with if_stall=1. Both are 32-bit, wrap, and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Shared package/header: state encodings FC_IDLE/FC_FETCH/FC_HOLD/FC_DROP, WORD_DATA_W, ISA_NOP, ENABLE/DISABLE.
- One sub-module, fetch_wait_timer: the saturating wait_cnt plus fetch_err flag, reused later by the data-memory controller.

Test Plan:
- Reset, then zero-wait memory with mem_rdy=1 always:
  - mem_addr sequence 0,4,8,12 on consecutive cycles.
  - if_stall=0 from cycle 2 after reset release.
- mem_rdy delayed 3 cycles at pc=0x10:
  - mem_req/mem_addr=0x10 stable for 4 cycles.
  - if_stall=1 for 3 cycles.
  - insn=mem_rdata and fetch_pc=0x10 on the 4th cycle.
- br_taken with br_addr=0x100 during the wait at pc=0x20, rdy 2 cycles later:
  - Data at 0x20 is dropped and insn stays NOP.
  - Next mem_addr=0x100.
  - flush together with br_taken (new_pc=0x200): next fetch is 0x200.
- id_stall held 5 cycles after a fetch of 0x40:
  - mem_req=0 and insn held.
  - After release, mem_addr=0x44.
- mem_rdy held low for MAX_WAIT=16 cycles:
  - fetch_err=1 at the 16th wait cycle and stays set after rdy.
  - Cleared by flush.
- With FETCH_PERF_CNT_EN, run 10 zero-wait fetches plus 3 stall cycles: perf_fetch=10, perf_stall=3 (post-reset cycles excluded after a counter clear check).
